axis_pkt_framer: RTL and testbench
==================================

# axis_pkt_framer

Single-clock AXI4-Stream packetizer that sits directly upstream of the packet-mode asynchronous AXIS FIFO. It takes a raw, unframed word stream, cuts it into packets of a configurable word count, and guarantees that every packet ends with a tlast. The FIFO releases data only on tlast, so the block also closes a partial packet when an idle timeout expires, so that no data is stranded in the FIFO.

## Interface
Parameters:
- DATA_WIDTH, 32: tdata width in bits; must be a multiple of 8.
- LEN_WIDTH, 16: width of cfg_pkt_len and of the internal word counter.
- TIMEOUT_CYCLES, 1024: number of consecutive idle cycles after which a partial packet is closed; must be ≥ 2.

Ports:
- clk  input  1  sole clock.
- rst  input  1  asynchronous, active-high reset.
- cfg_pkt_len  input  LEN_WIDTH  words per packet. Sampled on the first accepted beat of each packet. The value 0 is treated as 1.
- s_axis_tready  output  1  input ready.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tdata  input  DATA_WIDTH  input data.
- s_axis_tkeep  input  DATA_WIDTH/8  byte enables. Any value other than all-ones marks end of stream.
- m_axis_tready  input  1  downstream ready.
- m_axis_tvalid  output  1  output beat valid.
- m_axis_tdata  output  DATA_WIDTH  output data.
- m_axis_tkeep  output  DATA_WIDTH/8  output byte enables, passed through unchanged.
- m_axis_tlast  output  1  end of packet.
- stat_pkt_cnt  output  32  count of tlast beats handshaken on the output; wraps.
- stat_flush_cnt  output  32  count of timeout flushes; wraps.

## Operation
The datapath has two stages:
- a hold register (hold_valid, hold_data, hold_keep, hold_last);
- a registered output stage that drives the m_axis_* outputs.

Hold-register states:
- EMPTY: the hold register is empty.
- HOLD: a beat is held and is not yet known to be last.
- LAST: a beat is held and is marked last.

Definitions:
- out_free = !m_axis_tvalid || m_axis_tready.
- s_axis_tready = !rst && (state==EMPTY || out_free).
- "Accept" means s_axis_tvalid && s_axis_tready.

Word counter (word_cnt) and packet length:
- On an accept with word_cnt==0, the block latches len = max(cfg_pkt_len,1).
- The accepted beat is marked last if word_cnt==len-1 or if tkeep is not all-ones. On a last beat word_cnt resets to 0; otherwise it increments.

Transitions:
- EMPTY + accept: the beat is loaded into hold. Next state is LAST if the beat is marked last, otherwise HOLD.
- HOLD + accept: the held beat moves to the output stage with tlast=0 (out_free is guaranteed by s_axis_tready). The new beat is loaded into hold; next state is HOLD or LAST.
- HOLD, no accept, idle counter == TIMEOUT_CYCLES-1: set hold_last, reset word_cnt to 0, increment stat_flush_cnt. Next state is LAST.
- LAST + out_free: the held beat moves to the output stage with tlast=1. If an accept occurs in the same cycle, the new beat loads into hold (HOLD or LAST); otherwise next state is EMPTY.

Idle counter:
- Counts cycles spent in HOLD with no accept.
- Clears on any accept and on leaving HOLD.
- If an accept and a timeout would occur in the same cycle, the accept wins and no flush happens.

Output and statistics:
- The output stage holds tdata, tkeep and tlast stable while m_axis_tvalid && !m_axis_tready.
- stat_pkt_cnt increments on m_axis_tvalid && m_axis_tready && m_axis_tlast.

## Timing
- Reset (asynchronous, active-high): every output and all internal state go to 0 immediately. Any held or output beat is discarded and word_cnt restarts at 0. s_axis_tready is 1 on the first cycle after rst deasserts.
- Latency for a last beat: accepted at cycle t, m_axis_tvalid=1 with tlast=1 at t+2 when the output is free.
- A non-last beat stays in hold until the next accept or until the timeout. With a continuous input, throughput is 1 beat/cycle at 2 cycles latency.
- Flush timing: with no further input, a partial packet's final beat appears with tlast=1 exactly TIMEOUT_CYCLES+1 cycles after its hold-register load.
- Backpressure: no beat is dropped, duplicated or reordered. s_axis_tready deasserts only when the hold register is occupied and the output stage is stalled.

## Test plan
- Framing: cfg_pkt_len=4, 8 back-to-back beats 0..7, m_axis_tready=1 → tlast on data 3 and 7 only; stat_pkt_cnt=2; output exactly 0..7.
- Timeout flush: TIMEOUT_CYCLES=16, cfg_pkt_len=4, send beats 0,1, then idle → beat 1 exits with tlast=1 at 17 cycles after its hold load; stat_flush_cnt=1. The next beats 2..5 then form a full 4-word packet.
- Partial tkeep: cfg_pkt_len=8, third beat has tkeep=4'b0011 → tlast on that beat with tkeep=4'b0011 preserved; the next packet restarts its word count.
- Backpressure: cfg_pkt_len=5, 100 beats, m_axis_tready random at 50% → output matches input order; tlast every 5th beat; tdata stable throughout every stall.
- Reset mid-packet: assert rst with the block in HOLD and the output stalled → m_axis_tvalid=0 and stats=0 immediately. After release, cfg_pkt_len=2 with beats A,B → tlast on B.
- Degenerate length: cfg_pkt_len=1, then cfg_pkt_len=0 → tlast on every beat in both cases; stat_pkt_cnt equals the beat count.

Source files
------------

// File: rtl/axis_pkt_framer.sv
// axis_pkt_framer
// Cuts a raw AXI4-Stream word stream into packets of cfg_pkt_len words and
// always ends each packet with tlast. It feeds a packet-mode FIFO that
// releases data only on tlast, so a partial packet whose input has gone idle
// is closed after TIMEOUT_CYCLES idle cycles. This keeps data from being
// stranded in that FIFO.
//
// Datapath: hold register -> registered output stage.
// A beat waits in the hold register until the block knows whether it ends a
// packet. That is known when the next beat arrives, when the word count or
// tkeep says so, or when the idle timer expires.
//
// state   | meaning
// --------+------------------------------------------------------------
// EMPTY   | hold register empty
// HOLD    | hold register has a beat that is not yet known to be last
// LAST    | hold register has a beat that closes the current packet
module axis_pkt_framer #(
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LEN_WIDTH-1:0]    cfg_pkt_len,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [31:0]             stat_pkt_cnt,
  output logic [31:0]             stat_flush_cnt
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  // The idle counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int IDLE_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_WIDTH-1:0] IDLE_TERM = IDLE_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_LAST  = 2'd2
  } state_t;

  // hold register
  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
  logic [KEEP_WIDTH-1:0]   hold_keep_q, hold_keep_d;

  // output stage
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [KEEP_WIDTH-1:0]   out_keep_q, out_keep_d;
  logic                    out_last_q, out_last_d;

  // framing and idle timing
  logic [LEN_WIDTH-1:0]    word_cnt_q, word_cnt_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [IDLE_WIDTH-1:0]   idle_cnt_q, idle_cnt_d;

  // statistics
  logic [31:0]             pkt_cnt_q, pkt_cnt_d;
  logic [31:0]             flush_cnt_q, flush_cnt_d;

  logic                    out_free;
  logic                    in_ready;
  logic                    accept;
  logic                    keep_full;
  logic [LEN_WIDTH-1:0]    len_eff;
  logic                    beat_last;
  logic                    timeout_hit;

  assign out_free  = !out_valid_q || m_axis_tready;
  // Gating with rst keeps the input from accepting while reset is held.
  assign in_ready  = !rst && ((state_q == ST_EMPTY) || out_free);
  assign accept    = s_axis_tvalid && in_ready;
  assign keep_full = &s_axis_tkeep;

  // The first beat of a packet uses the live config; later beats use the
  // latched length, so changing cfg_pkt_len never splits a packet.
  assign len_eff   = (word_cnt_q == '0)
                     ? ((cfg_pkt_len == '0) ? LEN_ONE : cfg_pkt_len)
                     : len_q;
  assign beat_last = (word_cnt_q == (len_eff - LEN_ONE)) || !keep_full;

  // An accept in the same cycle as the terminal count wins, so no flush.
  assign timeout_hit = (state_q == ST_HOLD) && !accept && (idle_cnt_q == IDLE_TERM);

  // Next-state logic for the hold register, output stage, counters and stats.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    word_cnt_d  = word_cnt_q;
    len_d       = len_q;
    idle_cnt_d  = '0;
    pkt_cnt_d   = pkt_cnt_q;
    flush_cnt_d = flush_cnt_q;

    // The current output beat leaves unless something below replaces it.
    if (out_free) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      len_d      = len_eff;
      word_cnt_d = beat_last ? '0 : (word_cnt_q + LEN_ONE);
    end

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          hold_data_d = s_axis_tdata;
          hold_keep_d = s_axis_tkeep;
          state_d     = beat_last ? ST_LAST : ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (accept) begin
          // The new beat shows the held beat was not last. The input is only
          // ready in HOLD when the output is free.
          out_valid_d = 1'b1;
          out_data_d  = hold_data_q;
          out_keep_d  = hold_keep_q;
          out_last_d  = 1'b0;
          hold_data_d = s_axis_tdata;
          hold_keep_d = s_axis_tkeep;
          state_d     = beat_last ? ST_LAST : ST_HOLD;
        end else if (timeout_hit) begin
          // Close the partial packet; the next beat starts a new packet.
          state_d     = ST_LAST;
          word_cnt_d  = '0;
          flush_cnt_d = flush_cnt_q + 32'd1;
        end else begin
          idle_cnt_d  = idle_cnt_q + IDLE_WIDTH'(1);
        end
      end

      ST_LAST: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = hold_data_q;
          out_keep_d  = hold_keep_q;
          out_last_d  = 1'b1;
          if (accept) begin
            hold_data_d = s_axis_tdata;
            hold_keep_d = s_axis_tkeep;
            state_d     = beat_last ? ST_LAST : ST_HOLD;
          end else begin
            state_d     = ST_EMPTY;
          end
        end
      end

      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (out_valid_q && m_axis_tready && out_last_q) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  // State registers; reset drops any held or in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      word_cnt_q  <= '0;
      len_q       <= '0;
      idle_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      idle_cnt_q  <= idle_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign s_axis_tready  = in_ready;
  assign m_axis_tvalid  = out_valid_q;
  assign m_axis_tdata   = out_data_q;
  assign m_axis_tkeep   = out_keep_q;
  assign m_axis_tlast   = out_last_q;
  assign stat_pkt_cnt   = pkt_cnt_q;
  assign stat_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Testbench for axis_pkt_framer: the stimulus drives beats, and a reference
// model of the packetizing rules queues the expected output beats. A monitor
// pops that queue on every output handshake.
module tb_axis_pkt_framer;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int KW = DW / 8;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [LW-1:0] cfg_pkt_len = '0;
  logic          s_axis_tready;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata  = '0;
  logic [KW-1:0] s_axis_tkeep  = '0;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [31:0]   stat_pkt_cnt;
  logic [31:0]   stat_flush_cnt;

  axis_pkt_framer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .cfg_pkt_len(cfg_pkt_len),
    .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .stat_pkt_cnt(stat_pkt_cnt),
    .stat_flush_cnt(stat_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            acc;   // posedge index of the input handshake
    int            lat;   // required posedges from accept to output load, -1 = unchecked
  } beat_t;

  beat_t exp_q[$];
  beat_t e_m, b_m, pend_b;
  int    total = 0, bad = 0;
  int    cyc = 0;
  int    bp_mode = 0;   // 0: m_tready=1, 1: random, 2: m_tready=0
  int    lat_mode = 0;  // 1: every beat exits 1 posedge after accept, 2: flushed beats exit T+1 after
  bit    pend = 0;
  int    pos = 0, cur_len = 1, idle = 0;
  int    exp_pkts = 0, exp_flush = 0, out_cnt = 0;
  bit    stall_prev = 0;
  logic [DW-1:0] st_data;
  logic [KW-1:0] st_keep;
  logic          st_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready pattern, changed just after each posedge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Monitor, then reference model, both evaluated on the negedge for the handshake at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pend = 0; pos = 0; idle = 0;
      exp_pkts = 0; exp_flush = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", m_axis_tvalid, 1'b1);
        chk("stall_data", m_axis_tdata, st_data);
        chk("stall_keep", m_axis_tkeep, st_keep);
        chk("stall_last", m_axis_tlast, st_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", m_axis_tdata, 64'hDEAD);
        end else begin
          e_m = exp_q.pop_front();
          chk("out_data", m_axis_tdata, e_m.data);
          chk("out_keep", m_axis_tkeep, e_m.keep);
          chk("out_last", m_axis_tlast, e_m.last);
          if (e_m.lat >= 0) chk("latency", cyc - e_m.acc, e_m.lat);
          out_cnt++;
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      st_data = m_axis_tdata;
      st_keep = m_axis_tkeep;
      st_last = m_axis_tlast;

      // Reference model of the stream rules: packets of len words, an early
      // close on a partial tkeep, and an early close after T idle cycles behind a non-final beat.
      if (s_axis_tvalid && s_axis_tready) begin
        if (pos == 0) cur_len = (cfg_pkt_len == 0) ? 1 : int'(cfg_pkt_len);
        b_m.data = s_axis_tdata;
        b_m.keep = s_axis_tkeep;
        b_m.last = (pos == cur_len - 1) || (s_axis_tkeep != {KW{1'b1}});
        b_m.acc  = cyc + 1;
        b_m.lat  = (lat_mode == 1) ? 1 : -1;
        if (pend) begin
          exp_q.push_back(pend_b);
          pend = 0;
        end
        if (b_m.last) begin
          exp_q.push_back(b_m);
          exp_pkts++;
          pos = 0;
        end else begin
          pend_b = b_m;
          pend = 1;
          pos++;
        end
        idle = 0;
      end else if (pend) begin
        idle++;
        if (idle == T) begin
          pend_b.last = 1'b1;
          pend_b.lat  = (lat_mode == 2) ? T + 1 : -1;
          exp_q.push_back(pend_b);
          exp_pkts++;
          exp_flush++;
          pend = 0; pos = 0; idle = 0;
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k);
    int n;
    n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    while (1) begin
      @(negedge clk);
      if (s_axis_tready) break;
      n++;
      if (n > 500) begin
        chk("send_timeout", 1, 0);
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    s_axis_tvalid = 1'b0;
    while ((exp_q.size() != 0 || pend) && n < 400) begin
      @(posedge clk);
      #2;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(nm, (exp_q.size() == 0 && !pend), 1);
  endtask

  initial begin
    logic [31:0] pk0;
    int r;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_axis_tvalid, 0);
    chk("rst_s_ready", s_axis_tready, 0);
    chk("rst_pkt_cnt", stat_pkt_cnt, 0);
    chk("rst_flush_cnt", stat_flush_cnt, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", s_axis_tready, 1);
    @(posedge clk);
    #1;

    // framing: len 4, 8 back-to-back beats
    cfg_pkt_len = 4;
    lat_mode = 1;
    out_cnt = 0;
    for (int i = 0; i < 8; i++) send(DW'(i), 4'hF);
    drain("drain_framing");
    lat_mode = 0;
    chk("framing_out_cnt", out_cnt, 8);
    chk("framing_pkt_cnt", stat_pkt_cnt, 2);

    // timeout flush: beats 0,1 then idle; 2..5 form a full packet
    lat_mode = 2;
    send(32'h100, 4'hF);
    send(32'h101, 4'hF);
    idle_cyc(T + 10);
    lat_mode = 0;
    chk("flush_cnt", stat_flush_cnt, 1);
    for (int i = 2; i < 6; i++) send(32'h100 + DW'(i), 4'hF);
    drain("drain_flush");
    chk("flush_pkt_cnt", stat_pkt_cnt, 4);
    chk("flush_cnt_after", stat_flush_cnt, 1);

    // partial tkeep closes a packet; the next packet starts a new count
    cfg_pkt_len = 8;
    send(32'h200, 4'hF);
    send(32'h201, 4'hF);
    send(32'h202, 4'b0011);
    for (int i = 0; i < 8; i++) send(32'h210 + DW'(i), 4'hF);
    drain("drain_keep");
    chk("keep_pkt_cnt", stat_pkt_cnt, 6);

    // backpressure: len 5, 100 beats, random downstream ready
    cfg_pkt_len = 5;
    bp_mode = 1;
    for (int i = 0; i < 100; i++) send($urandom, 4'hF);
    drain("drain_bp");
    chk("bp_pkt_cnt", stat_pkt_cnt, exp_pkts);
    chk("bp_flush_cnt", stat_flush_cnt, exp_flush);

    // random lengths, partial keeps, gaps, and occasional long idles
    for (int i = 0; i < 150; i++) begin
      cfg_pkt_len = LW'($urandom_range(0, 6));
      r = $urandom_range(0, 9);
      send($urandom, (r == 0) ? 4'($urandom_range(0, 14)) : 4'hF);
      r = $urandom_range(0, 19);
      if (r < 4) idle_cyc($urandom_range(1, 3));
      else if (r == 19) idle_cyc(T + 4);
    end
    drain("drain_rand");
    chk("rand_pkt_cnt", stat_pkt_cnt, exp_pkts);
    chk("rand_flush_cnt", stat_flush_cnt, exp_flush);
    bp_mode = 0;
    @(posedge clk);
    #1;

    // degenerate lengths 1 and 0: every beat is last
    pk0 = stat_pkt_cnt;
    out_cnt = 0;
    cfg_pkt_len = 1;
    for (int i = 0; i < 5; i++) send(32'h300 + DW'(i), 4'hF);
    cfg_pkt_len = 0;
    for (int i = 0; i < 5; i++) send(32'h310 + DW'(i), 4'hF);
    drain("drain_degen");
    chk("degen_out_cnt", out_cnt, 10);
    chk("degen_pkt_delta", stat_pkt_cnt - pk0, 10);

    // reset mid-packet with the output stalled
    bp_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    cfg_pkt_len = 10;
    send(32'hA0, 4'hF);
    send(32'hB0, 4'hF);
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    chk("pre_rst_stalled", m_axis_tvalid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", m_axis_tvalid, 0);
    chk("midrst_pkt_cnt", stat_pkt_cnt, 0);
    chk("midrst_flush_cnt", stat_flush_cnt, 0);
    chk("midrst_s_ready", s_axis_tready, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    bp_mode = 0;
    #1;
    chk("ready_after_midrst", s_axis_tready, 1);
    @(posedge clk);
    #1;
    cfg_pkt_len = 2;
    send(32'hAA, 4'hF);
    send(32'hBB, 4'hF);
    drain("drain_after_rst");
    chk("post_rst_pkt_cnt", stat_pkt_cnt, 1);
    chk("post_rst_flush_cnt", stat_flush_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time limit on the run.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
